// File: rtl/div_hilo_ctrl_if.sv
// Pipeline and divider-facing signals of the divide sequencer.
// slave: the sequencer itself; master: the pipeline/divider side.
interface div_hilo_ctrl_if;
  logic        req;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_busy;
  logic [31:0] div_q;
  logic [31:0] div_r;

  modport slave (
    input  req, is_signed, dividend, divisor, mthi_we, mtlo_we, wdata,
    input  div_busy, div_q, div_r,
    output busy, done, error, hi, lo, div_start, div_dividend, div_divisor
  );

  modport master (
    output req, is_signed, dividend, divisor, mthi_we, mtlo_we, wdata,
    output div_busy, div_q, div_r,
    input  busy, done, error, hi, lo, div_start, div_dividend, div_divisor
  );
endinterface

// File: rtl/div_hilo_ctrl.sv
// Divide sequencer + HI/LO register file. Signed operands are reduced to
// magnitudes, the unsigned divider is launched with a one-cycle start, and
// its quotient/remainder are sign-corrected into LO/HI.
module div_hilo_ctrl #(
  parameter int          TIMEOUT    = 40,
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input logic            clock,
  input logic            reset,
  div_hilo_ctrl_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic          busy_q, done_q, error_q, start_q, neg_q, neg_r;
  logic [31:0]   hi_q, lo_q, mag_a_q, mag_b_q;
  logic [31:0]   mag_a, mag_b;

  // Operand magnitudes; 32-bit wrap keeps abs(0x80000000) = 0x80000000.
  always_comb begin
    mag_a = (bus.is_signed & bus.dividend[31]) ? (32'd0 - bus.dividend) : bus.dividend;
    mag_b = (bus.is_signed & bus.divisor[31])  ? (32'd0 - bus.divisor)  : bus.divisor;
  end

  // Sequencer, HI/LO file and divider handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      start_q  <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi_q     <= HILO_RESET;
      lo_q     <= HILO_RESET;
      mag_a_q  <= 32'd0;
      mag_b_q  <= 32'd0;
    end else begin
      done_q  <= 1'b0;
      start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            error_q <= 1'b0;
            if (bus.divisor != 32'd0) begin
              mag_a_q <= mag_a;
              mag_b_q <= mag_b;
              neg_q   <= bus.is_signed & (bus.dividend[31] ^ bus.divisor[31]);
              neg_r   <= bus.is_signed & bus.dividend[31];
              start_q <= 1'b1;
              busy_q  <= 1'b1;
              state   <= S_START;
            end else begin
              // Divide by zero resolves in IDLE without touching the divider.
              lo_q   <= 32'hFFFF_FFFF;
              hi_q   <= bus.dividend;
              done_q <= 1'b1;
            end
          end else begin
            if (bus.mthi_we) hi_q <= bus.wdata;
            if (bus.mtlo_we) lo_q <= bus.wdata;
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!bus.div_busy) begin
            lo_q   <= neg_q ? (32'd0 - bus.div_q) : bus.div_q;
            hi_q   <= neg_r ? (32'd0 - bus.div_r) : bus.div_r;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Divider never came back: abort, HI/LO keep their old values.
            error_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.hi           = hi_q;
  assign bus.lo           = lo_q;
  assign bus.div_start    = start_q;
  assign bus.div_dividend = mag_a_q;
  assign bus.div_divisor  = mag_b_q;
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Bench for div_hilo_ctrl: behavioural 32-iteration divider stub plus a
// plain-arithmetic reference for DIV/DIVU results and HI/LO contents.
module tb_div_hilo_ctrl;
  localparam int TIMEOUT = 40;

  logic clock, reset;
  div_hilo_ctrl_if bus ();

  div_hilo_ctrl #(.TIMEOUT(TIMEOUT), .HILO_RESET(32'h0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  // Divider stub: samples start, stays busy for 32 iterations.
  logic        stuck;
  logic        dbusy;
  int          dcnt;
  logic [31:0] dq, dr;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dbusy <= 1'b0; dcnt <= 0; dq <= 32'd0; dr <= 32'd0;
    end else if (bus.div_start && !dbusy) begin
      dbusy <= 1'b1;
      dcnt  <= 32;
      dq    <= (bus.div_divisor == 0) ? 32'hFFFF_FFFF : bus.div_dividend / bus.div_divisor;
      dr    <= (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
    end else if (dbusy) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) dbusy <= 1'b0;
    end
  end
  assign bus.div_busy = dbusy | stuck;
  assign bus.div_q    = dq;
  assign bus.div_r    = dr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic longint as_int(input bit sg, input logic [31:0] v);
    return sg ? longint'($signed(v)) : longint'(v);
  endfunction

  // Truncating division on wide integers, low 32 bits kept.
  task automatic ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    x = as_int(sg, a);
    y = as_int(sg, b);
    q = 32'(x / y);
    r = 32'(x % y);
  endtask

  function automatic logic [31:0] ref_mag(input bit sg, input logic [31:0] v);
    longint x;
    x = as_int(sg, v);
    return 32'(x < 0 ? -x : x);
  endfunction

  // mode: 0 plain, 1 inject req/mthi during WAIT, 2 reset mid-op, 3 stuck divider
  task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [31:0] eq, er;
    int n;
    bit seen;
    if (b != 0) ref_div(sg, a, b, eq, er);
    else begin eq = 32'hFFFF_FFFF; er = a; end
    if (mode == 3) begin eq = exp_lo; er = exp_hi; end
    @(negedge clock);
    bus.req = 1'b1; bus.is_signed = sg; bus.dividend = a; bus.divisor = b;
    @(negedge clock);
    bus.req = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    chk("busy_e0", 32'(bus.busy), 32'(b != 0));
    chk("start_e0", 32'(bus.div_start), 32'(b != 0));
    chk("err_clr", 32'(bus.error), 32'd0);
    if (b == 0) begin
      chk("done_dz", 32'(bus.done), 32'd1);
      chk("lo_dz", bus.lo, eq);
      chk("hi_dz", bus.hi, er);
      exp_lo = eq; exp_hi = er;
      @(negedge clock);
      chk("done_dz_1cyc", 32'(bus.done), 32'd0);
      chk("start_dz", 32'(bus.div_start), 32'd0);
      return;
    end
    chk("mag_a", bus.div_dividend, ref_mag(sg, a));
    chk("mag_b", bus.div_divisor, ref_mag(sg, b));
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clock); n++;
      @(negedge clock);
      if (n == 1) chk("start_1cyc", 32'(bus.div_start), 32'd0);
      if (mode == 1 && n == 10) begin
        bus.req = 1'b1; bus.mthi_we = 1'b1; bus.wdata = $urandom;
        bus.is_signed = 1'b0; bus.dividend = 32'd99; bus.divisor = 32'd5;
      end
      if (mode == 1 && n == 11) begin
        bus.req = 1'b0; bus.mthi_we = 1'b0;
      end
      if (mode == 2 && n == 10) begin
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
      end
      if (mode == 2 && n == 50) break;
      if (bus.done) seen = 1;
    end
    if (mode == 2) begin
      chk("rst_no_done", 32'(seen), 32'd0);
      chk("rst_hi_after", bus.hi, 32'd0);
      chk("rst_lo_after", bus.lo, 32'd0);
      return;
    end
    chk("latency", 32'(n), (mode == 3) ? 32'(TIMEOUT + 1) : 32'd34);
    chk("busy_done", 32'(bus.busy), 32'd0);
    chk("lo", bus.lo, eq);
    chk("hi", bus.hi, er);
    chk("error", 32'(bus.error), 32'(mode == 3));
    exp_lo = eq; exp_hi = er;
    @(negedge clock);
    chk("done_1cyc", 32'(bus.done), 32'd0);
  endtask

  task automatic mt(input bit h, input bit l, input logic [31:0] d);
    @(negedge clock);
    bus.mthi_we = h; bus.mtlo_we = l; bus.wdata = d;
    @(negedge clock);
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0;
    if (h) exp_hi = d;
    if (l) exp_lo = d;
    chk("mt_hi", bus.hi, exp_hi);
    chk("mt_lo", bus.lo, exp_lo);
  endtask

  initial begin
    reset = 1'b1; stuck = 1'b0;
    bus.req = 1'b0; bus.is_signed = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.wdata = 32'd0;
    repeat (3) @(negedge clock);
    chk("rst_busy0", 32'(bus.busy), 32'd0);
    chk("rst_done0", 32'(bus.done), 32'd0);
    chk("rst_err0", 32'(bus.error), 32'd0);
    chk("rst_start0", 32'(bus.div_start), 32'd0);
    chk("rst_hi0", bus.hi, 32'd0);
    chk("rst_lo0", bus.lo, 32'd0);
    chk("rst_dd0", bus.div_dividend, 32'd0);
    chk("rst_dv0", bus.div_divisor, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    do_op(1'b0, 32'd100, 32'd7, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(1'b0, 32'd1234, 32'd0, 0);
    do_op(1'b0, 32'd100, 32'd7, 2);
    do_op(1'b0, 32'd9, 32'd3, 0);
    do_op(1'b0, 32'd50, 32'd6, 1);
    mt(1'b0, 1'b1, 32'h55);
    mt(1'b1, 1'b0, 32'hA5A5_0001);
    mt(1'b1, 1'b1, 32'h1234_5678);

    // req wins over a same-cycle mthi write in IDLE
    @(negedge clock);
    bus.req = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd77; bus.divisor = 32'd0;
    bus.mthi_we = 1'b1; bus.wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    bus.req = 1'b0; bus.mthi_we = 1'b0;
    exp_hi = 32'd77; exp_lo = 32'hFFFF_FFFF;
    chk("prio_hi", bus.hi, exp_hi);
    chk("prio_lo", bus.lo, exp_lo);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 16));
        2: b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      do_op(1'($urandom_range(0, 1)), a, b, 0);
      if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    stuck = 1'b1;
    do_op(1'b1, 32'd1000, 32'd3, 3);
    stuck = 1'b0;
    chk("err_sticky", 32'(bus.error), 32'd1);
    do_op(1'b1, 32'hFFFF_FC18, 32'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
